core_inst_sequencer: RTL and testbench

// Autonomous driver for the core's 17-bit instruction bus and mem_in data bus. After a start

---
 rtl/core_inst_sequencer_if.sv | 27 ++
 rtl/core_inst_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_core_inst_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_inst_sequencer_if.sv
// Host-side stream and core-side instruction/data bundle of the instruction sequencer.
// The sequencer takes the master view; a host or stream source takes the slave view.
interface core_inst_sequencer_if #(
  parameter int bw = 8,
  parameter int pr = 8
);
  logic             start;
  logic [pr*bw-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [pr*bw-1:0] mem_in;
  logic [16:0]      inst;
  logic             busy;
  logic             out_valid;
  logic [3:0]       out_addr;
  logic             done;

  modport master (
    input  start, in_data, in_valid,
    output in_ready, mem_in, inst, busy, out_valid, out_addr, done
  );

  modport slave (
    output start, in_data, in_valid,
    input  in_ready, mem_in, inst, busy, out_valid, out_addr, done
  );
endinterface

// File: rtl/core_inst_sequencer.sv
// Drives the core's 17-bit instruction word and mem_in bus: streams Q/K vectors into
// qmem/kmem, then runs the fixed K-load, execute, writeback and pmem readout job.
module core_inst_sequencer #(
  parameter int bw          = 8,
  parameter int pr          = 8,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap         = 10
) (
  input logic                   clk,
  input logic                   reset,
  core_inst_sequencer_if.master bus
);
  localparam int OFIFO_RD = 16;
  localparam int EXECUTE  = 7;
  localparam int LOAD_BIT = 6;
  localparam int QMEM_RD  = 5;
  localparam int QMEM_WR  = 4;
  localparam int KMEM_RD  = 3;
  localparam int KMEM_WR  = 2;
  localparam int PMEM_RD  = 1;
  localparam int PMEM_WR  = 0;

  localparam logic [4:0] tc_last  = 5'(total_cycle - 1);
  localparam logic [4:0] col_last = 5'(col - 1);
  localparam logic [4:0] col_cnt  = 5'(col);
  localparam logic [4:0] gap_last = 5'(gap - 1);
  localparam logic [4:0] prd_last = 5'(2 * total_cycle - 1);

  typedef enum logic [3:0] {
    IDLE, QWR, KWR, GAP2, LOAD, LEND, LOFF, WAIT1,
    EXEC, EOFF, WAIT2, WB, WOFF, PRD, PDONE
  } state_t;

  state_t           state_reg;
  logic [4:0]       cnt_reg;
  logic [16:0]      inst_reg;
  logic [pr*bw-1:0] mem_in_reg;
  logic             out_valid_reg;
  logic [3:0]       out_addr_reg;
  logic             done_reg;

  logic       beat;
  logic [4:0] wr_last;
  logic [3:0] load_add;

  assign bus.in_ready  = (state_reg == QWR) || (state_reg == KWR);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.inst      = inst_reg;
  assign bus.mem_in    = mem_in_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_addr  = out_addr_reg;
  assign bus.done      = done_reg;

  assign beat    = bus.in_valid && bus.in_ready;
  assign wr_last = (state_reg == QWR) ? tc_last : col_last;
  // The first two load cycles share address 0 while kmem's read latency fills.
  assign load_add = (cnt_reg <= 5'd1) ? 4'd0 : 4'(cnt_reg - 5'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      inst_reg      <= '0;
      mem_in_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      done_reg      <= 1'b0;
    end else begin
      inst_reg      <= '0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg <= QWR;
            cnt_reg   <= '0;
          end
        end
        QWR, KWR: begin
          // A stalled cycle still presents the pending address, just without the write strobe.
          inst_reg[15:12] <= cnt_reg[3:0];
          if (beat) begin
            if (state_reg == QWR) inst_reg[QMEM_WR] <= 1'b1;
            else                  inst_reg[KMEM_WR] <= 1'b1;
            mem_in_reg <= bus.in_data;
            if (cnt_reg == wr_last) begin
              cnt_reg   <= '0;
              state_reg <= (state_reg == QWR) ? KWR : GAP2;
            end else begin
              cnt_reg <= cnt_reg + 5'd1;
            end
          end
        end
        GAP2: begin
          if (cnt_reg == 5'd1) begin
            cnt_reg   <= '0;
            state_reg <= LOAD;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        LOAD: begin
          inst_reg[LOAD_BIT] <= 1'b1;
          inst_reg[KMEM_RD]  <= (cnt_reg != 5'd0);
          inst_reg[15:12]    <= load_add;
          if (cnt_reg == col_cnt) begin
            cnt_reg   <= '0;
            state_reg <= LEND;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        LEND: begin
          inst_reg[LOAD_BIT] <= 1'b1;
          state_reg          <= LOFF;
        end
        LOFF: begin
          cnt_reg   <= '0;
          state_reg <= WAIT1;
        end
        WAIT1, WAIT2: begin
          if (cnt_reg == gap_last) begin
            cnt_reg   <= '0;
            state_reg <= (state_reg == WAIT1) ? EXEC : WB;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        EXEC: begin
          inst_reg[EXECUTE] <= 1'b1;
          inst_reg[QMEM_RD] <= 1'b1;
          inst_reg[15:12]   <= cnt_reg[3:0];
          if (cnt_reg == tc_last) begin
            cnt_reg   <= '0;
            state_reg <= EOFF;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        EOFF: begin
          cnt_reg   <= '0;
          state_reg <= WAIT2;
        end
        WB: begin
          inst_reg[OFIFO_RD] <= 1'b1;
          inst_reg[PMEM_WR]  <= 1'b1;
          inst_reg[11:8]     <= cnt_reg[3:0];
          if (cnt_reg == tc_last) begin
            cnt_reg   <= '0;
            state_reg <= WOFF;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        WOFF: begin
          cnt_reg   <= '0;
          state_reg <= PRD;
        end
        PRD: begin
          // Each address is held two cycles; pmem data is valid on the second.
          inst_reg[PMEM_RD] <= 1'b1;
          inst_reg[11:8]    <= cnt_reg[4:1];
          out_valid_reg     <= cnt_reg[0];
          out_addr_reg      <= cnt_reg[4:1];
          if (cnt_reg == prd_last) begin
            cnt_reg   <= '0;
            state_reg <= PDONE;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        PDONE: begin
          done_reg  <= 1'b1;
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_core_inst_sequencer.sv
// Bench for core_inst_sequencer: a small behavioural core model consumes the instruction
// stream, and each job's instruction trace is predicted from the job recipe.
module tb_core_inst_sequencer;
  localparam int BW = 8, PR = 8, COL = 8, TC = 8, GAP = 10, PSW = 20;
  localparam int VW = PR * BW;
  localparam int RW = COL * PSW;

  localparam logic [16:0] OFIFO_RD = 17'h10000;
  localparam logic [16:0] EXECUTE  = 17'h00080;
  localparam logic [16:0] LOAD     = 17'h00040;
  localparam logic [16:0] QMEM_RD  = 17'h00020;
  localparam logic [16:0] QMEM_WR  = 17'h00010;
  localparam logic [16:0] KMEM_RD  = 17'h00008;
  localparam logic [16:0] KMEM_WR  = 17'h00004;
  localparam logic [16:0] PMEM_RD  = 17'h00002;
  localparam logic [16:0] PMEM_WR  = 17'h00001;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  core_inst_sequencer_if #(.bw(BW), .pr(PR)) bus ();

  core_inst_sequencer #(
    .bw(BW), .pr(PR), .col(COL), .total_cycle(TC), .gap(GAP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [VW-1:0] q_vec [TC];
  logic [VW-1:0] k_vec [COL];
  logic [VW-1:0] mem_exp;

  logic [16:0] exp_inst [$];
  bit          exp_ov   [$];
  int          exp_oa   [$];
  bit          exp_done [$];

  function automatic logic [PSW-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [PSW-1:0] s;
    s = '0;
    for (int e = 0; e < PR; e++) s += PSW'(a[e*BW +: BW]) * PSW'(b[e*BW +: BW]);
    return s;
  endfunction

  function automatic logic [RW-1:0] expected_row(input int t);
    logic [RW-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[c*PSW +: PSW] = dot(q_vec[t], k_vec[c]);
    return r;
  endfunction

  // Behavioural core: memories written from the instruction bus, dot products on execute.
  logic [VW-1:0] qmem_m  [16];
  logic [VW-1:0] kmem_m  [16];
  logic [RW-1:0] pmem_m  [16];
  logic [RW-1:0] ofifo_q [$];
  logic [RW-1:0] pmem_out;

  function automatic logic [RW-1:0] model_row(input logic [3:0] a);
    logic [RW-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[c*PSW +: PSW] = dot(qmem_m[a], kmem_m[c]);
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      ofifo_q.delete();
      pmem_out <= '0;
    end else begin
      if (bus.inst[4] === 1'b1) qmem_m[bus.inst[15:12]] <= bus.mem_in;
      if (bus.inst[2] === 1'b1) kmem_m[bus.inst[15:12]] <= bus.mem_in;
      if (bus.inst[7] === 1'b1) ofifo_q.push_back(model_row(bus.inst[15:12]));
      if (bus.inst[16] === 1'b1 && bus.inst[0] === 1'b1 && ofifo_q.size() > 0)
        pmem_m[bus.inst[11:8]] <= ofifo_q.pop_front();
      if (bus.inst[1] === 1'b1) pmem_out <= pmem_m[bus.inst[11:8]];
    end
  end

  function automatic void push_word(input logic [16:0] w, input bit ov, input int oa, input bit dn);
    exp_inst.push_back(w);
    exp_ov.push_back(ov);
    exp_oa.push_back(oa);
    exp_done.push_back(dn);
  endfunction

  task automatic run_job(input int stall_beat, input bit rand_valid,
                         input bit start_in_exec, input bit reset_in_wb);
    int            n = 0, stall_left = 3, cyc = 0, idx, exec_i, wb_i;
    int            ov_seen = 0, done_seen = 0;
    bit            v;
    logic [VW-1:0] data;
    logic [16:0]   exp_w;

    for (int t = 0; t < TC; t++)
      for (int e = 0; e < PR; e++) q_vec[t][e*BW +: BW] = BW'($urandom);
    for (int c = 0; c < COL; c++)
      for (int e = 0; e < PR; e++) k_vec[c][e*BW +: BW] = BW'($urandom);

    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b exp 1", bus.busy); end
    checks++;
    if (bus.inst !== 17'd0) begin errors++; $display("FAIL start_inst got %h exp 0", bus.inst); end

    while (n < TC + COL) begin
      if (cyc == 400) begin
        errors++;
        $display("FAIL beat_budget accepted %0d beats exp %0d", n, TC + COL);
        break;
      end
      idx = (n < TC) ? n : n - TC;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL in_ready beat %0d got %b exp 1", n, bus.in_ready); end
      if (n == stall_beat && stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end else begin
        v = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      data = v ? ((n < TC) ? q_vec[n] : k_vec[idx]) : VW'({$urandom, $urandom});
      bus.in_valid = v;
      bus.in_data  = data;
      @(posedge clk); #1;
      exp_w = 17'(idx) << 12;
      if (v) begin
        exp_w   = exp_w | ((n < TC) ? QMEM_WR : KMEM_WR);
        mem_exp = data;
      end
      checks++;
      if (bus.inst !== exp_w) begin errors++; $display("FAIL wr_inst beat %0d valid %b got %h exp %h", n, v, bus.inst, exp_w); end
      checks++;
      if (bus.mem_in !== mem_exp) begin errors++; $display("FAIL mem_in beat %0d got %h exp %h", n, bus.mem_in, mem_exp); end
      if (v) n++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_after_k got %b exp 0", bus.in_ready); end
    $display("stream: %0d beats in %0d cycles", n, cyc);

    exp_inst.delete(); exp_ov.delete(); exp_oa.delete(); exp_done.delete();
    push_word(17'd0, 1'b0, 0, 1'b0);
    push_word(17'd0, 1'b0, 0, 1'b0);
    for (int i = 0; i <= COL; i++)
      push_word(LOAD | ((i > 0) ? KMEM_RD : 17'd0) | (17'((i < 2) ? 0 : i - 1) << 12), 1'b0, 0, 1'b0);
    push_word(LOAD, 1'b0, 0, 1'b0);
    for (int i = 0; i <= GAP; i++) push_word(17'd0, 1'b0, 0, 1'b0);
    exec_i = exp_inst.size();
    for (int t = 0; t < TC; t++) push_word(EXECUTE | QMEM_RD | (17'(t) << 12), 1'b0, 0, 1'b0);
    for (int i = 0; i <= GAP; i++) push_word(17'd0, 1'b0, 0, 1'b0);
    wb_i = exp_inst.size();
    for (int t = 0; t < TC; t++) push_word(OFIFO_RD | PMEM_WR | (17'(t) << 8), 1'b0, 0, 1'b0);
    push_word(17'd0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 2 * TC; i++) push_word(PMEM_RD | (17'(i / 2) << 8), bit'(i % 2), i / 2, 1'b0);
    push_word(17'd0, 1'b0, 0, 1'b1);

    for (int i = 0; i < exp_inst.size(); i++) begin
      bus.start = start_in_exec && (i == exec_i + 2);
      if (reset_in_wb && i == wb_i + 3) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        mem_exp = '0;
        checks++;
        if (bus.inst !== 17'd0) begin errors++; $display("FAIL rst_wb_inst got %h exp 0", bus.inst); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_wb_busy got %b exp 0", bus.busy); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_wb_ready got %b exp 0", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
          errors++; $display("FAIL rst_wb_flags got ov %b done %b exp 0 0", bus.out_valid, bus.done);
        end
        $display("job aborted by reset at writeback step 3");
        return;
      end
      @(posedge clk); #1;
      checks++;
      if (bus.inst !== exp_inst[i]) begin errors++; $display("FAIL job_inst[%0d] got %h exp %h", i, bus.inst, exp_inst[i]); end
      checks++;
      if (bus.busy !== !exp_done[i]) begin errors++; $display("FAIL job_busy[%0d] got %b exp %b", i, bus.busy, !exp_done[i]); end
      checks++;
      if (bus.out_valid !== exp_ov[i]) begin errors++; $display("FAIL job_out_valid[%0d] got %b exp %b", i, bus.out_valid, exp_ov[i]); end
      checks++;
      if (bus.done !== exp_done[i]) begin errors++; $display("FAIL job_done[%0d] got %b exp %b", i, bus.done, exp_done[i]); end
      if (exp_ov[i]) begin
        checks++;
        if (bus.out_addr !== 4'(exp_oa[i])) begin errors++; $display("FAIL out_addr[%0d] got %0d exp %0d", i, bus.out_addr, exp_oa[i]); end
        checks++;
        if (pmem_out !== expected_row(exp_oa[i])) begin
          errors++; $display("FAIL pmem_row %0d got %h exp %h", exp_oa[i], pmem_out, expected_row(exp_oa[i]));
        end else begin
          $display("readout addr %0d: %h", exp_oa[i], pmem_out);
        end
      end
      if (bus.out_valid === 1'b1) ov_seen++;
      if (bus.done === 1'b1) done_seen++;
    end
    bus.start = 1'b0;

    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.inst !== 17'd0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL post_job got busy %b inst %h done %b exp 0 0 0", bus.busy, bus.inst, bus.done);
    end
    checks++;
    if (ov_seen != TC) begin errors++; $display("FAIL ov_count got %0d exp %0d", ov_seen, TC); end
    checks++;
    if (done_seen != 1) begin errors++; $display("FAIL done_count got %0d exp 1", done_seen); end
    $display("job complete: %0d readouts, %0d done pulses", ov_seen, done_seen);
  endtask

  task automatic test_reset();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    reset        = 1'b1;
    mem_exp      = '0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.inst !== 17'd0) begin errors++; $display("FAIL reset_inst got %h exp 0", bus.inst); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.out_addr !== 4'd0) begin
      errors++; $display("FAIL reset_out got ov %b done %b addr %0d exp 0", bus.out_valid, bus.done, bus.out_addr);
    end
    checks++;
    if (bus.mem_in !== '0) begin errors++; $display("FAIL reset_mem_in got %h exp 0", bus.mem_in); end
    // reset and start together: reset wins
    reset     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_over_start got busy %b exp 0", bus.busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.inst !== 17'd0) begin
      errors++; $display("FAIL idle_hold got busy %b inst %h exp 0 0", bus.busy, bus.inst);
    end
    $display("reset sequence checked");
  endtask

  task automatic test_basic_stream();
    run_job(-1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stream_stall();
    run_job(4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random_job();
    run_job(-1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_start_in_exec();
    run_job(-1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_wb();
    run_job(-1, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_abort got busy %b exp 0", bus.busy); end
    run_job(-1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job(-1, 1'b1, 1'b0, 1'b0);
    run_job(2, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_stream_stall();
    test_random_job();
    test_start_in_exec();
    test_reset_mid_wb();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
